// File: rtl/jk_bank_driver.sv
// -----------------------------------------------------------------------------
// jk_bank_driver
//
// Write-side excitation driver for a bank of W JK flip-flops sharing clk and
// reset with this block. A target word is accepted over a valid/ready
// handshake. The driver then walks a shadow copy of the bank toward the target.
// It changes at most MAX_FLIPS bits per cycle, lowest index first, and emits
// the matching per-bit J/K commands.
//
// Parameters:
//   W          bank width in bits (1..32)
//   MAX_FLIPS  maximum bits changed per drive cycle (1..W)
//   USE_TOGGLE 0: set/reset encoding (0->1 as j=1,k=0; 1->0 as j=0,k=1)
//              1: toggle encoding (j=1,k=1)
//
// Ports:
//   clk        rising-edge clock, shared with the JK bank
//   reset      synchronous active-high reset, also resets the bank to 0
//   tgt_data   requested bank state
//   tgt_valid  tgt_data valid
//   tgt_ready  high while IDLE (combinational from state)
//   j, k       registered J/K excitation, one bit per bank flip-flop
//   busy       high while in DRIVE
//   done       one-cycle pulse once the shadow equals the target
//   q_fb       bank Q feedback            (only with JKDRV_VERIFY_EN)
//   mismatch   sticky feedback error flag (only with JKDRV_VERIFY_EN)
//
// Optional feature macro: JKDRV_VERIFY_EN adds bank feedback checking.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a target; j=k=0, tgt_ready=1
// DRIVE | stepping the shadow toward the target, MAX_FLIPS bits/cycle
// -----------------------------------------------------------------------------
module jk_bank_driver #(
   parameter int W          = 8,
   parameter int MAX_FLIPS  = 2,
   parameter int USE_TOGGLE = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] tgt_data,
   input  logic         tgt_valid,
   output logic         tgt_ready,
   output logic [W-1:0] j,
   output logic [W-1:0] k,
   output logic         busy,
   output logic         done
`ifdef JKDRV_VERIFY_EN
   ,
   input  logic [W-1:0] q_fb,
   output logic         mismatch
`endif
);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t       state;
   logic [W-1:0] shadow;
   logic [W-1:0] target;

   logic [W-1:0] diff;
   logic [W-1:0] sel;
   logic [W-1:0] rest;
   logic [W-1:0] j_nxt;
   logic [W-1:0] k_nxt;
   int           n_sel;

   assign tgt_ready = (state == IDLE);

   // Pick the lowest-indexed set bits of diff, up to MAX_FLIPS of them.
   always_comb begin
      diff  = shadow ^ target;
      sel   = '0;
      n_sel = 0;
      for (int i = 0; i < W; i++) begin
         if (diff[i] && (n_sel < MAX_FLIPS)) begin
            sel[i] = 1'b1;
            n_sel  = n_sel + 1;
         end
      end
      rest = diff & ~sel;
   end

   // Encoding is derived from the current shadow bit. In set/reset mode,
   // j and k are disjoint, so j=k=1 never appears.
   always_comb begin
      j_nxt = '0;
      k_nxt = '0;
      if (USE_TOGGLE != 0) begin
         j_nxt = sel;
         k_nxt = sel;
      end else begin
         j_nxt = sel & ~shadow;
         k_nxt = sel & shadow;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         shadow <= '0;
         target <= '0;
         j      <= '0;
         k      <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               j    <= '0;
               k    <= '0;
               done <= 1'b0;
               if (tgt_valid) begin
                  target <= tgt_data;
                  busy   <= 1'b1;
                  state  <= DRIVE;
               end
            end
            DRIVE: begin
               j      <= j_nxt;
               k      <= k_nxt;
               shadow <= shadow ^ sel;
               // This is the last step when nothing remains beyond this
               // cycle's selection. It also covers target == shadow.
               if (rest == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef JKDRV_VERIFY_EN
   // The bank applies j/k one edge after the shadow updates, so Q should
   // match the shadow delayed by one cycle. The first cycle out of reset is
   // not checked.
   logic [W-1:0] exp;
   logic         armed;

   always_ff @(posedge clk) begin
      if (reset) begin
         exp      <= '0;
         armed    <= 1'b0;
         mismatch <= 1'b0;
      end else begin
         exp   <= shadow;
         armed <= 1'b1;
         if (armed && (q_fb != exp))
            mismatch <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboarded bench for jk_bank_driver. Two instances share the same stimulus:
// one uses set/reset encoding and the other uses toggle encoding. Each drives
// its own behavioural JK bank.
module tb_jk_bank_driver;
   localparam int W  = 8;
   localparam int MF = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] tgt_data = '0;
   logic         tgt_valid = 1'b0;

   logic         rdy0, rdy1, busy0, busy1, done0, done1;
   logic [W-1:0] j0, k0, j1, k1;
   logic [W-1:0] bank0 = '0;
   logic [W-1:0] bank1 = '0;

`ifdef JKDRV_VERIFY_EN
   logic [W-1:0] fb_force = '0;
   logic         mm0, mm1;
   logic         exp_mm = 1'b0;
`endif

   always #5 clk = ~clk;

   jk_bank_driver #(.W(W), .MAX_FLIPS(MF), .USE_TOGGLE(0)) dut0 (
      .clk(clk), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
      .tgt_ready(rdy0), .j(j0), .k(k0), .busy(busy0), .done(done0)
`ifdef JKDRV_VERIFY_EN
      , .q_fb(bank0 & ~fb_force), .mismatch(mm0)
`endif
   );

   jk_bank_driver #(.W(W), .MAX_FLIPS(MF), .USE_TOGGLE(1)) dut1 (
      .clk(clk), .reset(reset), .tgt_data(tgt_data), .tgt_valid(tgt_valid),
      .tgt_ready(rdy1), .j(j1), .k(k1), .busy(busy1), .done(done1)
`ifdef JKDRV_VERIFY_EN
      , .q_fb(bank1), .mismatch(mm1)
`endif
   );

   // JK characteristic equation: Q+ = J&~Q | ~K&Q
   function automatic logic [W-1:0] jk_next(input logic [W-1:0] q,
                                            input logic [W-1:0] jj,
                                            input logic [W-1:0] kk);
      return (jj & ~q) | (~kk & q);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         bank0 <= '0;
         bank1 <= '0;
      end else begin
         bank0 <= jk_next(bank0, j0, k0);
         bank1 <= jk_next(bank1, j1, k1);
      end
   end

   typedef struct {
      logic [W-1:0] js;   // set/reset encoding: expected j
      logic [W-1:0] ks;   // set/reset encoding: expected k
      logic [W-1:0] jt;   // toggle encoding: expected j == k
      logic         last;
      logic [W-1:0] tgt;
   } step_t;

   step_t        sbq[$];
   logic [W-1:0] model_state = '0;
   int           n_chk = 0;
   int           n_fail = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: list the differing bit positions in ascending order,
   // group them into chunks of MF, and emit one step per chunk.
   task automatic push_target(input logic [W-1:0] t);
      logic [W-1:0] d;
      logic [W-1:0] mask;
      int           idx[$];
      step_t        s;
      d = model_state ^ t;
      for (int i = 0; i < W; i++) if (d[i]) idx.push_back(i);
      if (idx.size() == 0) begin
         s.js = '0; s.ks = '0; s.jt = '0; s.last = 1'b1; s.tgt = t;
         sbq.push_back(s);
      end else begin
         for (int c = 0; c < idx.size(); c += MF) begin
            mask = '0;
            for (int m = c; m < c + MF && m < idx.size(); m++) mask[idx[m]] = 1'b1;
            s.js   = mask & t;
            s.ks   = mask & ~t;
            s.jt   = mask;
            s.last = (c + MF >= idx.size());
            s.tgt  = t;
            sbq.push_back(s);
         end
      end
      model_state = t;
   endtask

   // Monitor: samples on the falling edge and pops one step per drive cycle.
   initial begin : monitor
      logic         prev_busy;
      logic         exp_busy;
      logic         chk_bank;
      logic [W-1:0] bank_exp;
      step_t        it;
      prev_busy = 1'b0;
      chk_bank  = 1'b0;
      bank_exp  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_busy = 1'b0;
            chk_bank  = 1'b0;
         end else begin
            if (chk_bank) begin
               chk("bank0_final", bank0, bank_exp);
               chk("bank1_final", bank1, bank_exp);
               chk_bank = 1'b0;
            end
            if (prev_busy) begin
               if (sbq.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL sb_underflow: actual empty required step at %0t", $time);
               end else begin
                  it = sbq.pop_front();
                  chk("j_sr", j0, it.js);
                  chk("k_sr", k0, it.ks);
                  chk("j_tg", j1, it.jt);
                  chk("k_tg", k1, it.jt);
                  chk("done_sr", W'(done0), W'(it.last));
                  chk("done_tg", W'(done1), W'(it.last));
                  if (it.last) begin
                     chk_bank = 1'b1;
                     bank_exp = it.tgt;
                  end
               end
            end else begin
               chk("j_idle_sr", j0, '0);
               chk("k_idle_sr", k0, '0);
               chk("j_idle_tg", j1, '0);
               chk("k_idle_tg", k1, '0);
               chk("done_idle_sr", W'(done0), '0);
               chk("done_idle_tg", W'(done1), '0);
            end
            exp_busy = (sbq.size() != 0);
            chk("busy_sr", W'(busy0), W'(exp_busy));
            chk("busy_tg", W'(busy1), W'(exp_busy));
            chk("ready_sr", W'(rdy0), W'(!exp_busy));
            chk("ready_tg", W'(rdy1), W'(!exp_busy));
`ifdef JKDRV_VERIFY_EN
            chk("mismatch_sr", W'(mm0), W'(exp_mm));
            chk("mismatch_tg", W'(mm1), '0);
`endif
            prev_busy = exp_busy;
         end
      end
   end

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      reset = 1'b1;
      sbq.delete();
      model_state = '0;
`ifdef JKDRV_VERIFY_EN
      exp_mm = 1'b0;
`endif
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] t);
      int waited;
      waited = 0;
      tgt_data  = t;
      tgt_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (rdy0) break;
         waited++;
         if (waited > 60) break;
      end
      if (waited > 60) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: actual no ready required ready within 60 cycles");
         tgt_valid = 1'b0;
      end else begin
         @(posedge clk);
         push_target(t);
         #1;
         tgt_valid = 1'b0;
         tgt_data  = W'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (n >= 100) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: actual %0d steps left required 0", sbq.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset state, then 0x00 -> 0x0F.
      @(negedge clk);
      chk("reset_bank", bank0, '0);
      @(posedge clk);
      #1;
      send(8'h0F);
      wait_idle();

`ifdef JKDRV_VERIFY_EN
      // Corrupt feedback bit 3 for one cycle while the bank holds 0x0F.
      fb_force = 8'h08;
      @(posedge clk);
      #1;
      fb_force = '0;
      exp_mm = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      do_reset(2);
      send(8'h0F);
      wait_idle();
`endif

      // 0x0F -> 0xF0 (four steps), then the same target again.
      send(8'hF0);
      wait_idle();
      send(8'hF0);
      wait_idle();
      chk("bank_same_target", bank0, 8'hF0);

      // From 0x00, target 0x81 completes in one step; the toggle bank
      // sees j=k=0x81.
      do_reset(2);
      send(8'h81);
      wait_idle();

      // Reset during DRIVE, then recover.
      do_reset(2);
      send(8'hFF);
      do_reset(1);
      @(negedge clk);
      chk("bank_after_abort", bank0, '0);
      chk("busy_after_abort", W'(busy0), '0);
      @(posedge clk);
      #1;
      send(8'h01);
      wait_idle();

      // Random targets: back-to-back and with idle gaps.
      for (int r = 0; r < 60; r++) begin
         send(W'($urandom_range(0, 255)));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
